// File: rtl/mod_add_32_if.sv
// Request/response bundle for the byte-serial modular adder: operands and start in, result and status out.
interface mod_add_32_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] n;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        err;

    modport master (
        output start, a, b, n,
        input  result, done, busy, err
    );

    modport slave (
        input  start, a, b, n,
        output result, done, busy, err
    );
endinterface

// File: rtl/mod_add_32.sv
// Byte-serial (a + b) mod n: 8 cycles start->done, one op per 10 cycles; start ignored while busy (no queuing).
// Optional operand range check is enabled by defining MOD_ADD_RANGE_CHECK_EN.
module mod_add_32 (
    input  logic        clk,
    input  logic        rst,
    mod_add_32_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_idx;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_n;
    logic [31:0] r_s;
    logic [31:0] r_d;
    logic [31:0] r_result;
    logic        r_carry;
    logic        r_borrow;
    logic        r_c32;

    logic [4:0]  w_bit_ofs;
    logic [7:0]  w_a_byte;
    logic [7:0]  w_b_byte;
    logic [7:0]  w_n_byte;
    logic [7:0]  w_s_byte;
    logic [8:0]  w_sum9;
    logic [8:0]  w_diff9;
    logic [31:0] w_d_full;
    logic [31:0] w_res_nxt;
    logic        w_sel_d;
    logic        w_start_acc;
    logic        w_last_byte;

    assign w_bit_ofs   = {r_idx, 3'b000};
    assign w_a_byte    = r_a[w_bit_ofs +: 8];
    assign w_b_byte    = r_b[w_bit_ofs +: 8];
    assign w_n_byte    = r_n[w_bit_ofs +: 8];
    assign w_s_byte    = r_s[w_bit_ofs +: 8];
    assign w_last_byte = (r_idx == 2'd3);
    assign w_start_acc = (r_state == ST_IDLE) && bus.start;

    assign w_sum9  = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'd0, r_carry};
    assign w_diff9 = {1'b0, w_s_byte} - {1'b0, w_n_byte} - {8'd0, r_borrow};

    // Top byte of d is still combinational on the last SUB cycle, so splice it in here.
    assign w_d_full = {w_diff9[7:0], r_d[23:0]};
    assign w_sel_d  = r_c32 | ~w_diff9[8];

`ifdef MOD_ADD_RANGE_CHECK_EN
    logic r_viol;
    logic r_err;
    logic w_viol;

    assign w_viol    = (bus.n == 32'd0) || (bus.a >= bus.n) || (bus.b >= bus.n);
    assign w_res_nxt = r_viol ? 32'd0 : (w_sel_d ? w_d_full : r_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_viol <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_start_acc) begin
            r_viol <= w_viol;
            r_err  <= 1'b0;
        end else if ((r_state == ST_SUB) && w_last_byte) begin
            r_err  <= r_viol;
        end
    end

    assign bus.err = r_err;
`else
    assign w_res_nxt = w_sel_d ? w_d_full : r_s;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start)  w_state_nxt = ST_ADD;
            ST_ADD:  if (w_last_byte) w_state_nxt = ST_SUB;
            ST_SUB:  if (w_last_byte) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= 2'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_n      <= 32'd0;
            r_s      <= 32'd0;
            r_d      <= 32'd0;
            r_result <= 32'd0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_c32    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_n      <= bus.n;
                        r_carry  <= 1'b0;
                        r_borrow <= 1'b0;
                        r_idx    <= 2'd0;
                    end
                end
                ST_ADD: begin
                    r_s[w_bit_ofs +: 8] <= w_sum9[7:0];
                    r_carry             <= w_sum9[8];
                    r_idx               <= r_idx + 2'd1;
                    if (w_last_byte) begin
                        r_c32 <= w_sum9[8];
                    end
                end
                ST_SUB: begin
                    r_d[w_bit_ofs +: 8] <= w_diff9[7:0];
                    r_borrow            <= w_diff9[8];
                    r_idx               <= r_idx + 2'd1;
                    if (w_last_byte) begin
                        r_result <= w_res_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.done   = (r_state == ST_DONE);
    assign bus.busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mod_add_32.sv
// Directed bench for mod_add_32: latency, arithmetic corner cases, start filtering, async reset, range check.
module tb_mod_add_32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mod_add_32_if bus ();

    mod_add_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
        bus.a     = a;
        bus.b     = b;
        bus.n     = n;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'hDEAD_BEEF;
        bus.n     = 32'h0000_0003;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.n     = 32'd1;
        #1;
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want %h", bus.result, 32'd0); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        do_start(32'd5, 32'd7, 32'd11);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b want 1", bus.busy); end
        wait_done(lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL basic_result: got %h want %h", bus.result, 32'd1); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle: got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_k9: got %b want 0", bus.busy); end
        checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL basic_result_held: got %h want %h", bus.result, 32'd1); end
    endtask

    task automatic test_no_sub_and_boundary();
        int lat;
        do_start(32'd3, 32'd4, 32'd100);
        wait_done(lat);
        checks++; if (bus.result !== 32'd7) begin errors++; $display("FAIL nosub_result: got %h want %h (lat %0d)", bus.result, 32'd7, lat); end
        @(posedge clk);
        #1;
        do_start(32'd6, 32'd5, 32'd11);
        wait_done(lat);
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL s_eq_n_result: got %h want %h (lat %0d)", bus.result, 32'd0, lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry();
        int lat;
        do_start(32'h0000_00FF, 32'h0000_0001, 32'h0001_0000);
        wait_done(lat);
        checks++; if (bus.result !== 32'h0000_0100) begin errors++; $display("FAIL carry_result: got %h want %h (lat %0d)", bus.result, 32'h0000_0100, lat); end
        @(posedge clk);
        #1;
        do_start(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_done(lat);
        checks++; if (bus.result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL c32_wrap_result: got %h want %h (lat %0d)", bus.result, 32'hFFFF_FFFD, lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int lat;
        bit seen;
        do_start(32'd5, 32'd7, 32'd11);
        repeat (2) begin @(posedge clk); #1; end
        bus.a = 32'd1; bus.b = 32'd1; bus.n = 32'd50; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 1'b0;
        lat  = 3;
        for (int c = 4; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen || lat != 8) begin errors++; $display("FAIL ignore_latency: got %0d want 8", seen ? lat : -1); end
        checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL ignore_k3_result: got %h want %h", bus.result, 32'd1); end
        bus.a = 32'd2; bus.b = 32'd2; bus.n = 32'd50; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_k9_busy: got %b want 0", bus.busy); end
        checks++; if (bus.result !== 32'd1) begin errors++; $display("FAIL ignore_k9_result: got %h want %h", bus.result, 32'd1); end
        do_start(32'd10, 32'd20, 32'd25);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL accept_k10_busy: got %b want 1", bus.busy); end
        wait_done(lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL accept_k10_latency: got %0d want 8", lat); end
        checks++; if (bus.result !== 32'd5) begin errors++; $display("FAIL accept_k10_result: got %h want %h", bus.result, 32'd5); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        do_start(32'd5, 32'd7, 32'd11);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h want %h", bus.result, 32'd0); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", bus.err); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_start(32'd9, 32'd8, 32'd11);
        wait_done(lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_restart_latency: got %0d want 8", lat); end
        checks++; if (bus.result !== 32'd6) begin errors++; $display("FAIL midrst_restart_result: got %h want %h", bus.result, 32'd6); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_range();
        int lat;
        do_start(32'd20, 32'd1, 32'd11);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL range_err_before_done: got %b want 0", bus.err); end
        wait_done(lat);
`ifdef MOD_ADD_RANGE_CHECK_EN
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL range_err_set: got %b want 1", bus.err); end
        checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL range_result_forced: got %h want %h", bus.result, 32'd0); end
        @(posedge clk);
        #1;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL range_err_held: got %b want 1", bus.err); end
`else
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL range_err_disabled: got %b want 0", bus.err); end
        @(posedge clk);
        #1;
`endif
        do_start(32'd1, 32'd2, 32'd11);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL range_err_cleared: got %b want 0", bus.err); end
        wait_done(lat);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL range_ok_err: got %b want 0", bus.err); end
        checks++; if (bus.result !== 32'd3) begin errors++; $display("FAIL range_ok_result: got %h want %h (lat %0d)", bus.result, 32'd3, lat); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_sub_and_boundary();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
